// File: rtl/dram_rsp_assembler.sv
// Read-response assembler: packs LSB-first DRAM read bits into DATA_WIDTH-bit words
// and queues them in a small FIFO for the L2 valid/ready port.
module dram_rsp_assembler #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst_b,
    input  logic                               rd_bit_valid,
    input  logic                               rd_bit,
    output logic                               rd_bit_ready,
    input  logic                               flush,
    output logic                               l2_rsp_valid,
    output logic [DATA_WIDTH-1:0]              l2_rsp_data,
    input  logic                               l2_rsp_ready,
    output logic [$clog2(RSP_DEPTH+1)-1:0]     fifo_level,
    output logic                               partial
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(RSP_DEPTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_rdy;
    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [DATA_WIDTH-1:0] w_hold_nxt;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_space;
    logic [PTR_W-1:0]      w_wr_ptr_nxt;
    logic [PTR_W-1:0]      w_rd_ptr_nxt;
    logic [LVL_W-1:0]      w_level_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;

    // Assembly FSM: flush wins, then completion pushes or parks the word in HOLD
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_shift_nxt = r_shift;
        w_hold_nxt  = r_hold;
        w_push      = 1'b0;
        w_push_data = r_hold;
        w_accept    = rd_bit_valid && r_rdy && !flush;
        w_pop       = r_valid && l2_rsp_ready;
        w_space     = (r_level != LVL_W'(RSP_DEPTH)) || w_pop;
        w_word      = r_shift;
        w_word[r_count] = rd_bit;

        if (flush) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_shift_nxt = '0;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                IDLE, FILL: begin
                    if (w_accept) begin
                        if (r_count == CNT_W'(DATA_WIDTH - 1)) begin
                            w_count_nxt = '0;
                            w_shift_nxt = '0;
                            if (w_space) begin
                                w_push      = 1'b1;
                                w_push_data = w_word;
                                w_state_nxt = IDLE;
                            end else begin
                                w_hold_nxt  = w_word;
                                w_state_nxt = HOLD;
                            end
                        end else begin
                            w_count_nxt = r_count + CNT_W'(1);
                            w_shift_nxt = w_word;
                            w_state_nxt = FILL;
                        end
                    end
                end
                HOLD: begin
                    if (w_space) begin
                        w_push      = 1'b1;
                        w_push_data = r_hold;
                        w_hold_nxt  = '0;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FIFO bookkeeping; head register bypasses a push that lands on the new head slot
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push);
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
        w_level_nxt  = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
        w_data_nxt = r_data;
        if (w_level_nxt != '0) begin
            if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
                w_data_nxt = w_push_data;
            end else begin
                w_data_nxt = r_mem[w_rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_shift  <= '0;
            r_hold   <= '0;
            r_rdy    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_shift  <= w_shift_nxt;
            r_hold   <= w_hold_nxt;
            r_rdy    <= (w_state_nxt != HOLD);
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_valid  <= (w_level_nxt != '0);
            r_data   <= w_data_nxt;
        end
    end

    // Storage array needs no reset: the pointers and level define its validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign rd_bit_ready = r_rdy;
    assign l2_rsp_valid = r_valid;
    assign l2_rsp_data  = r_data;
    assign fifo_level   = r_level;
    assign partial      = (r_state != IDLE);

endmodule

// File: tb/tb_dram_rsp_assembler.sv
// Randomized and directed bench for dram_rsp_assembler against a queue-based
// reference model of word assembly, hold-on-full and FIFO ordering.
module tb_dram_rsp_assembler;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst_b;
    logic       rd_bit_valid;
    logic       rd_bit;
    logic       rd_bit_ready;
    logic       flush;
    logic       l2_rsp_valid;
    logic [7:0] l2_rsp_data;
    logic       l2_rsp_ready;
    logic [2:0] fifo_level;
    logic       partial;

    dram_rsp_assembler #(.DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) u_dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .rd_bit_valid (rd_bit_valid),
        .rd_bit       (rd_bit),
        .rd_bit_ready (rd_bit_ready),
        .flush        (flush),
        .l2_rsp_valid (l2_rsp_valid),
        .l2_rsp_data  (l2_rsp_data),
        .l2_rsp_ready (l2_rsp_ready),
        .fifo_level   (fifo_level),
        .partial      (partial)
    );

    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned max_lvl;

    // Reference model: words waiting for L2, the word being collected, a parked word
    logic [7:0] m_q[$];
    int         m_nbits;
    int         m_acc;
    bit         m_held;
    logic [7:0] m_hword;
    bit         m_rdy;
    logic [7:0] dut_pops[$];

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit         pop;
        bit         push;
        logic [7:0] pw;
        push = 1'b0;
        pw   = '0;
        pop  = (m_q.size() != 0) && l2_rsp_ready;
        if (rst_b && l2_rsp_valid && l2_rsp_ready) dut_pops.push_back(l2_rsp_data);
        if (!rst_b) begin
            m_q.delete();
            m_nbits = 0;
            m_acc   = 0;
            m_held  = 1'b0;
            m_rdy   = 1'b0;
            return;
        end
        if (flush) begin
            m_nbits = 0;
            m_acc   = 0;
            m_held  = 1'b0;
        end else if (m_held) begin
            if (m_q.size() < DEPTH || pop) begin
                push   = 1'b1;
                pw     = m_hword;
                m_held = 1'b0;
            end
        end else if (rd_bit_valid && m_rdy) begin
            m_acc = m_acc | (int'(rd_bit) << m_nbits);
            m_nbits++;
            if (m_nbits == DW) begin
                if (m_q.size() < DEPTH || pop) begin
                    push = 1'b1;
                    pw   = 8'(m_acc);
                end else begin
                    m_held  = 1'b1;
                    m_hword = 8'(m_acc);
                end
                m_nbits = 0;
                m_acc   = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(pw);
        m_rdy = !m_held;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("rdy",     32'(rd_bit_ready), 32'(m_rdy));
        chk("valid",   32'(l2_rsp_valid), 32'(m_q.size() != 0));
        chk("level",   32'(fifo_level),   32'(m_q.size()));
        chk("partial", 32'(partial),      32'((m_nbits != 0) || m_held));
        if (m_q.size() != 0) chk("data", 32'(l2_rsp_data), 32'(m_q[0]));
        if (!rst_b) chk("rst_data", 32'(l2_rsp_data), 32'(0));
        if (32'(fifo_level) > max_lvl) max_lvl = 32'(fifo_level);
    endtask

    // mode 0: L2 ready untouched, 1: random L2 ready, 2: L2 ready only on the last bit
    task automatic send_word(input logic [7:0] w, input int mode);
        for (int i = 0; i < 8; i++) begin
            int guard;
            bit took;
            guard = 0;
            rd_bit_valid = 1'b1;
            rd_bit       = w[i];
            if (mode == 2) l2_rsp_ready = (i == 7);
            forever begin
                if (mode == 1) l2_rsp_ready = 1'($urandom_range(0, 1));
                took = rd_bit_ready && !flush;
                step();
                if (took) break;
                guard++;
                if (guard > 64) begin
                    chk("bit_timeout", 32'(0), 32'(1));
                    break;
                end
            end
        end
        if (mode == 2) l2_rsp_ready = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        rd_bit_valid = 1'b0;
        l2_rsp_ready = 1'b1;
        while (m_q.size() != 0 || m_held) begin
            step();
            guard++;
            if (guard > 40) begin
                chk("drain_timeout", 32'(0), 32'(1));
                break;
            end
        end
        l2_rsp_ready = 1'b0;
    endtask

    task automatic check_pop(input string tag, input logic [7:0] w);
        if (dut_pops.size() == 0) chk(tag, 32'hFFFF, 32'(w));
        else                      chk(tag, 32'(dut_pops.pop_front()), 32'(w));
    endtask

    initial begin
        n_vec = 0; n_err = 0; max_lvl = 0;
        m_nbits = 0; m_acc = 0; m_held = 1'b0; m_hword = '0; m_rdy = 1'b0;
        clk = 1'b0; rst_b = 1'b0; rd_bit_valid = 1'b0; rd_bit = 1'b0;
        flush = 1'b0; l2_rsp_ready = 1'b0;

        step(); step();
        chk("rst_rdy", 32'(rd_bit_ready), 32'(0));
        rst_b = 1'b1;
        step();
        chk("rel_rdy", 32'(rd_bit_ready), 32'(1));

        // Single word 0xA5
        send_word(8'hA5, 0);
        rd_bit_valid = 1'b0;
        chk("a5_data",    32'(l2_rsp_data),  32'h0A5);
        chk("a5_valid",   32'(l2_rsp_valid), 32'(1));
        chk("a5_level",   32'(fifo_level),   32'(1));
        chk("a5_partial", 32'(partial),      32'(0));
        drain();
        check_pop("a5_pop", 8'hA5);
        chk("a5_extra", 32'(dut_pops.size()), 32'(0));

        // Backpressure into HOLD, release by a single pop
        for (int w = 1; w <= 5; w++) send_word(8'(w), 0);
        rd_bit_valid = 1'b0;
        chk("bp_level",   32'(fifo_level),   32'(4));
        chk("bp_rdy",     32'(rd_bit_ready), 32'(0));
        chk("bp_partial", 32'(partial),      32'(1));
        l2_rsp_ready = 1'b1;
        step();
        l2_rsp_ready = 1'b0;
        step();
        chk("bp_rel_rdy",   32'(rd_bit_ready), 32'(1));
        chk("bp_rel_level", 32'(fifo_level),   32'(4));
        drain();
        for (int w = 1; w <= 5; w++) check_pop("bp_pop", 8'(w));
        chk("bp_extra", 32'(dut_pops.size()), 32'(0));

        // Flush mid-word, then a clean word
        for (int i = 0; i < 3; i++) begin
            rd_bit_valid = 1'b1; rd_bit = 1'b1; step();
        end
        rd_bit_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_partial", 32'(partial), 32'(0));
        send_word(8'h3C, 0);
        drain();
        check_pop("fl_pop", 8'h3C);
        chk("fl_extra", 32'(dut_pops.size()), 32'(0));

        // Flush coincident with the last bit
        for (int i = 0; i < 7; i++) begin
            rd_bit_valid = 1'b1; rd_bit = 1'b1; step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0; rd_bit_valid = 1'b0;
        step();
        chk("fl8_level",   32'(fifo_level), 32'(0));
        chk("fl8_partial", 32'(partial),    32'(0));

        // Completion while full with a pop in the same cycle
        for (int w = 8'h21; w <= 8'h24; w++) send_word(8'(w), 0);
        send_word(8'h25, 2);
        rd_bit_valid = 1'b0;
        chk("pp4_level", 32'(fifo_level),   32'(4));
        chk("pp4_rdy",   32'(rd_bit_ready), 32'(1));
        drain();
        for (int w = 8'h21; w <= 8'h25; w++) check_pop("pp4_pop", 8'(w));

        // Same at level 2
        send_word(8'h31, 0);
        send_word(8'h32, 0);
        send_word(8'h33, 2);
        rd_bit_valid = 1'b0;
        chk("pp2_level", 32'(fifo_level), 32'(2));
        drain();
        for (int w = 8'h31; w <= 8'h33; w++) check_pop("pp2_pop", 8'(w));
        chk("pp_extra", 32'(dut_pops.size()), 32'(0));

        // Pointer wrap with random L2 ready
        max_lvl = 0;
        for (int w = 8'h10; w <= 8'h1B; w++) send_word(8'(w), 1);
        drain();
        for (int w = 8'h10; w <= 8'h1B; w++) check_pop("wrap_pop", 8'(w));
        chk("wrap_extra",  32'(dut_pops.size()), 32'(0));
        chk("wrap_maxlvl", 32'(max_lvl <= 4),    32'(1));

        // Reset while in HOLD with a full FIFO
        for (int w = 8'h41; w <= 8'h45; w++) send_word(8'(w), 0);
        rd_bit_valid = 1'b0;
        chk("rm_rdy_hold", 32'(rd_bit_ready), 32'(0));
        rst_b = 1'b0;
        step();
        chk("rm_rdy",     32'(rd_bit_ready), 32'(0));
        chk("rm_valid",   32'(l2_rsp_valid), 32'(0));
        chk("rm_level",   32'(fifo_level),   32'(0));
        chk("rm_partial", 32'(partial),      32'(0));
        rst_b = 1'b1;
        step();
        dut_pops.delete();
        send_word(8'h5A, 0);
        drain();
        check_pop("rm_pop", 8'h5A);
        chk("rm_extra", 32'(dut_pops.size()), 32'(0));

        // Random soak including occasional flushes
        for (int c = 0; c < 400; c++) begin
            rd_bit_valid = ($urandom_range(0, 3) != 0);
            rd_bit       = 1'($urandom_range(0, 1));
            l2_rsp_ready = ($urandom_range(0, 2) == 0);
            flush        = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dram_rsp_assembler.md
# dram_rsp_assembler

Read-response stage directly downstream of `dram_ctrl`. It collects the 1-bit-per-column read data returned from the DRAM array into `DATA_WIDTH`-bit words and buffers them in a small FIFO. It then presents the words to the L2 side on a valid/ready interface. It replaces the ad-hoc `l2_rsp_data` path and keeps the L2 side fed only during reads.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per assembled response word; also the number of DRAM bit beats per word.
- `RSP_DEPTH`, 4: response FIFO depth in words; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_b`  in  1  reset, synchronous and active-low.
- `rd_bit_valid`  in  1  a DRAM read bit is presented this cycle.
- `rd_bit`  in  1  DRAM read data bit.
- `rd_bit_ready`  out  1  block accepts `rd_bit` this cycle; registered.
- `flush`  in  1  discards the partial or held word; FIFO contents are kept.
- `l2_rsp_valid`  out  1  FIFO head is valid.
- `l2_rsp_data`  out  `DATA_WIDTH`  FIFO head word.
- `l2_rsp_ready`  in  1  L2 consumes the head word when it is high together with `l2_rsp_valid`.
- `fifo_level`  out  `$clog2(RSP_DEPTH+1)`  number of words stored in the FIFO.
- `partial`  out  1  a word is under assembly or held; high in FILL or HOLD.

## Operation
- Bit accept: `rd_bit_valid && rd_bit_ready && !flush`.
- Bit order: LSB first. The k-th accepted bit of a word (k = 0..`DATA_WIDTH`-1) lands in `shift[k]`. The bit counter is `$clog2(DATA_WIDTH)` wide.
- FSM states and transitions:
  - IDLE (count 0). A bit accept writes bit 0, sets count to 1, and moves to FILL. When `DATA_WIDTH` is 1, it takes the FILL completion path instead.
  - FILL. Each bit accept increments count. On the accept of bit `DATA_WIDTH`-1 the word completes:
    - if the FIFO is not full, or a pop occurs this cycle, the word is pushed, count clears, and the FSM goes to IDLE;
    - otherwise the word is copied to the hold register and the FSM goes to HOLD.
  - HOLD. `rd_bit_ready` is 0. In the first cycle where the FIFO is not full or a pop occurs, the hold word is pushed and the FSM goes to IDLE.
- `rd_bit_ready` is a register equal to (next state != HOLD).
- Flush: highest priority in every state. It clears count and the shift/hold register and sends the FSM to IDLE. Any bit presented in the same cycle is dropped, and no push occurs.
- FIFO: circular, with `$clog2(RSP_DEPTH)`-bit read and write pointers that wrap from `RSP_DEPTH`-1 to 0.
  - `fifo_level` is +1 on push only, -1 on pop only, and unchanged on push and pop together.
  - Pop: `l2_rsp_valid && l2_rsp_ready`. `l2_rsp_ready` while the FIFO is empty is ignored.
  - A push never happens when the level is `RSP_DEPTH` without a pop in the same cycle.
- `l2_rsp_data` holds its last value while `l2_rsp_valid` is 0; consumers must not sample it then.

## Timing
- Reset values: `rd_bit_ready`=0 while `rst_b`=0 and 1 from the first edge after release; `l2_rsp_valid`=0; `l2_rsp_data`=0; `fifo_level`=0; `partial`=0; FSM in IDLE; pointers and count 0.
- Reset mid-word or mid-HOLD discards everything, including FIFO contents.
- Latency:
  - last bit accepted at edge N gives `l2_rsp_valid`=1 and the word visible after edge N, so L2 can sample it at edge N+1;
  - HOLD release is one cycle after the pop edge that frees space.
- Throughput: one bit per cycle in steady state, so one word per `DATA_WIDTH` cycles. No bubble between words unless HOLD is entered.
- `flush` asserted together with the last bit: the word is not pushed and `fifo_level` is unchanged.
- Pop and word completion at full FIFO in the same cycle: the push proceeds with no HOLD, and the level stays `RSP_DEPTH`.
- `rd_bit_ready` has no combinational dependence on `l2_rsp_ready` or `rd_bit_valid`.

## Test plan
- Single word: after reset, send bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles (LSB first), `l2_rsp_ready`=0. Expect `l2_rsp_data`=0xA5 and `l2_rsp_valid`=1 one edge after the 8th bit, `fifo_level`=1, `partial`=0.
- Backpressure: with `l2_rsp_ready`=0, stream 5 words 0x01..0x05. Expect:
  - `fifo_level`=4;
  - after the 40th bit, `rd_bit_ready`=0 and FSM in HOLD;
  - after one pop, 0x01 is returned, 0x05 is pushed the next cycle, and `rd_bit_ready` returns to 1;
  - draining yields 0x02, 0x03, 0x04, 0x05 in order.
- Flush: after 3 bits of 0xFF, assert `flush` for 1 cycle, then send 0x3C. Expect exactly one word, 0x3C, and `partial`=0 in the cycle after flush. Repeat with `flush` coincident with the 8th bit: no word is pushed.
- Simultaneous push and pop:
  - FIFO at level 4 with `l2_rsp_ready`=1 while a word completes: no HOLD, level stays 4, order preserved;
  - at level 2: level stays 2.
- Pointer wrap: 12 words through the FIFO (0x10..0x1B) with random `l2_rsp_ready`. Every word is returned exactly once, in order, and `fifo_level` never exceeds 4.
- Reset mid-operation: `rst_b`=0 for 1 cycle during HOLD with the FIFO full. Expect all outputs at reset values on the next edge, and a subsequent 0x5A returned alone.
